// File: rtl/mmio_sig_pkg.sv
// mmio_sig_pkg: shared types and constants for the MMIO signature monitor.
//   state_e    - monitor FSM states
//   cause_e    - encoding of the reason the run ended
//   dump_rec_t - one register-dump record held in the dump FIFO
//   DEF_*      - default signature addresses of the tiny-SoC benchmark program
package mmio_sig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_STOP   = 2'd1,
    CAUSE_TRAP   = 2'd2,
    CAUSE_SIMLEN = 2'd3
  } cause_e;

  // Record data field width; the monitor's DATA_W must not exceed it.
  localparam int unsigned REC_DATA_W = 32'd64;

  typedef struct packed {
    logic [2:0]            ch;
    logic [5:0]            idx;
    logic [REC_DATA_W-1:0] data;
  } dump_rec_t;

  localparam logic [30:0] DEF_STOP_ADDR      = 31'h6000_0000;
  localparam logic [30:0] DEF_TRAP_ADDR      = 31'h6000_0008;
  localparam logic [30:0] DEF_DUMP_BASE_ADDR = 31'h6000_0010;

  // Integer registers start at x1 (x0 is never dumped); other channels at 0.
  function automatic logic [5:0] idx_rst_val(input int unsigned ch);
    return (ch == 32'd0) ? 6'd1 : 6'd0;
  endfunction

endpackage

// File: rtl/mmio_sig_fifo.sv
// sig_fifo: synchronous FIFO of dump_rec_t records.
//   clk, rst - clock, asynchronous active-high reset
//   wr_en    - push request (accepted when not full, or when a pop frees a slot)
//   wr_data  - record to push
//   rd_en    - pop request (ignored while empty)
//   rd_data  - head record (meaningful only while !empty)
//   full     - registered full flag
//   empty    - registered empty flag
module sig_fifo
  import mmio_sig_pkg::*;
#(
  parameter int unsigned DEPTH = 32'd8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  dump_rec_t wr_data,
  input  logic      rd_en,
  output dump_rec_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  dump_rec_t        mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop; a full FIFO still accepts a push when the head leaves.
  always_comb begin
    do_pop_s  = rd_en & ~empty_r;
    do_push_s = wr_en & (~full_r | do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + (AW + 1)'(1'b1);
      2'b01:   count_nxt_s = count_r - (AW + 1)'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Record storage; contents need no reset because the flags gate them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == (AW + 1)'(DEPTH));
      empty_r <= (count_nxt_s == {(AW + 1){1'b0}});
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/mmio_sig_monitor.sv
// mmio_sig_monitor: watches the tiny-SoC MMIO write port for the benchmark's
// stop, trap and register-dump signature writes.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   en_i                  - arms the monitor (IDLE -> RUN)
//   stop_on_trap_i        - a trap write ends the run when set
//   simlen_i              - cycle limit, 0 = unlimited
//   mmio_req/we/addr/wdata- MMIO write port being observed
//   dump_valid/ready/ch/idx/data - FIFO of dump records towards the host
//   dump_ovf_o            - sticky, a dump record was dropped
//   trap_seen_o/trap_cnt_o- trap pulse and saturating trap count
//   cycle_cnt_o           - saturating RUN+DRAIN cycle count
//   done_o/done_cause_o   - sticky end of run and its cause
module mmio_sig_monitor
  import mmio_sig_pkg::*;
#(
  parameter int unsigned          ADDR_W         = 32'd31,
  parameter int unsigned          DATA_W         = 32'd64,
  parameter logic [ADDR_W-1:0]    STOP_ADDR      = DEF_STOP_ADDR,
  parameter logic [ADDR_W-1:0]    TRAP_ADDR      = DEF_TRAP_ADDR,
  parameter logic [ADDR_W-1:0]    DUMP_BASE_ADDR = DEF_DUMP_BASE_ADDR,
  parameter int unsigned          N_DUMP_CH      = 32'd2,
  parameter int unsigned          DRAIN_CYCLES   = 32'd500,
  parameter int unsigned          FIFO_DEPTH     = 32'd8,
  parameter int unsigned          CNT_W          = 32'd32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              stop_on_trap_i,
  input  logic [CNT_W-1:0]  simlen_i,
  input  logic              mmio_req_i,
  input  logic              mmio_we_i,
  input  logic [ADDR_W-1:0] mmio_addr_i,
  input  logic [DATA_W-1:0] mmio_wdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [2:0]        dump_ch_o,
  output logic [5:0]        dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_ovf_o,
  output logic              trap_seen_o,
  output logic [CNT_W-1:0]  trap_cnt_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              done_o,
  output logic [1:0]        done_cause_o
);

  localparam int unsigned      DRAIN_W = (DRAIN_CYCLES < 32'd1) ? 32'd1 : $clog2(DRAIN_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_r;
  cause_e               cause_r;
  logic [DRAIN_W-1:0]   drain_cnt_r;
  logic [CNT_W-1:0]     cycle_cnt_r;
  logic [CNT_W-1:0]     trap_cnt_r;
  logic                 trap_seen_r;
  logic                 done_r;
  logic                 ovf_r;
  logic [5:0]           idx_r [N_DUMP_CH];

  logic                 wr_s;
  logic                 run_s;
  logic                 active_s;
  logic                 stop_hit_s;
  logic                 trap_hit_s;
  logic                 simlen_hit_s;
  logic [N_DUMP_CH-1:0] dump_hit_vec_s;
  logic [2:0]           dump_ch_s;
  logic [5:0]           dump_idx_s;
  logic                 push_s;
  logic                 drop_s;
  dump_rec_t            rec_s;
  dump_rec_t            head_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;

  // Signature decode and run-control conditions for the current cycle.
  always_comb begin
    wr_s         = mmio_req_i & mmio_we_i;
    run_s        = (state_r == RUN);
    active_s     = (state_r == RUN) | (state_r == DRAIN);
    stop_hit_s   = wr_s & (mmio_addr_i == STOP_ADDR);
    trap_hit_s   = wr_s & (mmio_addr_i == TRAP_ADDR);
    simlen_hit_s = active_s & (simlen_i != {CNT_W{1'b0}}) &
                   (cycle_cnt_r == (simlen_i - CNT_W'(1'b1)));
  end

  // Dump channel decode; channel addresses are distinct so at most one hits.
  always_comb begin
    dump_hit_vec_s = {N_DUMP_CH{1'b0}};
    dump_ch_s      = 3'd0;
    dump_idx_s     = 6'd0;
    for (int c = 0; c < N_DUMP_CH; c++) begin
      if (wr_s && (mmio_addr_i == DUMP_BASE_ADDR + ADDR_W'(32'd8 * c))) begin
        dump_hit_vec_s[c] = 1'b1;
        dump_ch_s         = 3'(c);
        dump_idx_s        = idx_r[c];
      end else begin
        dump_hit_vec_s[c] = 1'b0;
      end
    end
  end

  // Build the record; a dump is dropped only when full and no pop frees a slot.
  always_comb begin
    push_s     = run_s & (|dump_hit_vec_s);
    drop_s     = push_s & fifo_full_s & ~dump_ready_i;
    rec_s.ch   = dump_ch_s;
    rec_s.idx  = dump_idx_s;
    rec_s.data = REC_DATA_W'(mmio_wdata_i);
  end

  sig_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (push_s),
    .wr_data (rec_s),
    .rd_en   (dump_ready_i),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Per-channel register index; advances on every accepted hit, even dropped ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_DUMP_CH; c++) begin
        idx_r[c] <= idx_rst_val(c);
      end
    end else begin
      for (int c = 0; c < N_DUMP_CH; c++) begin
        if (run_s && dump_hit_vec_s[c]) begin
          idx_r[c] <= idx_r[c] + 6'd1;
        end
      end
    end
  end

  // Run-control FSM with counters, trap pulse, overflow and done flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      cause_r     <= CAUSE_NONE;
      drain_cnt_r <= {DRAIN_W{1'b0}};
      cycle_cnt_r <= {CNT_W{1'b0}};
      trap_cnt_r  <= {CNT_W{1'b0}};
      trap_seen_r <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      trap_seen_r <= run_s & trap_hit_s;
      if (run_s && trap_hit_s && (trap_cnt_r != CNT_MAX)) begin
        trap_cnt_r <= trap_cnt_r + CNT_W'(1'b1);
      end
      if (active_s && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (en_i) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          // The cycle limit wins over a stop landing on the same edge.
          if (simlen_hit_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            cause_r <= CAUSE_SIMLEN;
          end else if (stop_hit_s) begin
            state_r     <= DRAIN;
            cause_r     <= CAUSE_STOP;
            drain_cnt_r <= DRAIN_W'(DRAIN_CYCLES);
          end else if (trap_hit_s && stop_on_trap_i) begin
            state_r     <= DRAIN;
            cause_r     <= CAUSE_TRAP;
            drain_cnt_r <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          // Zero is tested before decrementing, giving DRAIN_CYCLES+1 drain cycles.
          if (simlen_hit_s || (drain_cnt_r == {DRAIN_W{1'b0}})) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - DRAIN_W'(1'b1);
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO head fields are forced to zero while nothing valid is presented.
  assign dump_valid_o = ~fifo_empty_s;
  assign dump_ch_o    = fifo_empty_s ? 3'd0 : head_s.ch;
  assign dump_idx_o   = fifo_empty_s ? 6'd0 : head_s.idx;
  assign dump_data_o  = fifo_empty_s ? {DATA_W{1'b0}} : DATA_W'(head_s.data);
  assign dump_ovf_o   = ovf_r;
  assign trap_seen_o  = trap_seen_r;
  assign trap_cnt_o   = trap_cnt_r;
  assign cycle_cnt_o  = cycle_cnt_r;
  assign done_o       = done_r;
  assign done_cause_o = cause_r;

endmodule

// File: tb/tb_mmio_sig_monitor.sv
// tb_mmio_sig_monitor: directed self-checking bench for mmio_sig_monitor
// with default parameters (DRAIN_CYCLES=500, FIFO_DEPTH=8, two channels).
module tb_mmio_sig_monitor;

  localparam logic [30:0] A_STOP = 31'h6000_0000;
  localparam logic [30:0] A_TRAP = 31'h6000_0008;
  localparam logic [30:0] A_CH0  = 31'h6000_0010;
  localparam logic [30:0] A_CH1  = 31'h6000_0018;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        stop_on_trap_i;
  logic [31:0] simlen_i;
  logic        mmio_req_i;
  logic        mmio_we_i;
  logic [30:0] mmio_addr_i;
  logic [63:0] mmio_wdata_i;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [2:0]  dump_ch_o;
  logic [5:0]  dump_idx_o;
  logic [63:0] dump_data_o;
  logic        dump_ovf_o;
  logic        trap_seen_o;
  logic [31:0] trap_cnt_o;
  logic [31:0] cycle_cnt_o;
  logic        done_o;
  logic [1:0]  done_cause_o;

  int checks = 0;
  int errors = 0;
  int n;
  logic [72:0] exp_q [$];

  mmio_sig_monitor dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .stop_on_trap_i (stop_on_trap_i),
    .simlen_i       (simlen_i),
    .mmio_req_i     (mmio_req_i),
    .mmio_we_i      (mmio_we_i),
    .mmio_addr_i    (mmio_addr_i),
    .mmio_wdata_i   (mmio_wdata_i),
    .dump_valid_o   (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .dump_ch_o      (dump_ch_o),
    .dump_idx_o     (dump_idx_o),
    .dump_data_o    (dump_data_o),
    .dump_ovf_o     (dump_ovf_o),
    .trap_seen_o    (trap_seen_o),
    .trap_cnt_o     (trap_cnt_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .done_o         (done_o),
    .done_cause_o   (done_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [30:0] addr, input logic [63:0] data);
    mmio_req_i   = 1'b1;
    mmio_we_i    = 1'b1;
    mmio_addr_i  = addr;
    mmio_wdata_i = data;
    step();
    mmio_req_i   = 1'b0;
    mmio_we_i    = 1'b0;
    mmio_addr_i  = 31'd0;
    mmio_wdata_i = 64'd0;
  endtask

  task automatic sample_head();
    logic [72:0] e;
    if (dump_valid_o !== 1'b1) begin
      check("head_valid", 80'(dump_valid_o), 80'(1'b1));
    end else if (exp_q.size() == 0) begin
      check("head_unexpected", 80'({dump_ch_o, dump_idx_o, dump_data_o}), 80'(73'd0));
    end else begin
      e = exp_q.pop_front();
      check("head_rec", 80'({dump_ch_o, dump_idx_o, dump_data_o}), 80'(e));
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done_o !== 1'b1 && cnt < 700) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    en_i           = 1'b0;
    stop_on_trap_i = 1'b0;
    simlen_i       = 32'd0;
    mmio_req_i     = 1'b0;
    mmio_we_i      = 1'b0;
    mmio_addr_i    = 31'd0;
    mmio_wdata_i   = 64'd0;
    dump_ready_i   = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset state and hits ignored in IDLE
    do_reset();
    check("rst_done", 80'(done_o), 80'(1'b0));
    check("rst_cause", 80'(done_cause_o), 80'(2'd0));
    check("rst_valid", 80'(dump_valid_o), 80'(1'b0));
    check("rst_head", 80'({dump_ch_o, dump_idx_o, dump_data_o}), 80'(73'd0));
    check("rst_cycle", 80'(cycle_cnt_o), 80'(32'd0));
    wr(A_STOP, 64'd1);
    wr(A_TRAP, 64'd2);
    check("idle_trap_seen", 80'(trap_seen_o), 80'(1'b0));
    check("idle_trap_cnt", 80'(trap_cnt_o), 80'(32'd0));
    check("idle_cycle", 80'(cycle_cnt_o), 80'(32'd0));

    // Stop at cycle 20, done exactly 501 cycles later
    en_i = 1'b1;
    step();
    repeat (19) step();
    wr(A_STOP, 64'd0);
    check("stop_cycle", 80'(cycle_cnt_o), 80'(32'd20));
    check("stop_done_early", 80'(done_o), 80'(1'b0));
    wait_done(n);
    check("stop_drain_len", 80'(n), 80'(32'd501));
    check("stop_cause", 80'(done_cause_o), 80'(2'd1));
    check("stop_cycle_end", 80'(cycle_cnt_o), 80'(32'd521));
    wr(A_TRAP, 64'd0);
    step();
    check("done_trap_ignored", 80'(trap_cnt_o), 80'(32'd0));
    check("done_cycle_frozen", 80'(cycle_cnt_o), 80'(32'd521));
    check("done_sticky", 80'(done_o), 80'(1'b1));

    // Traps without and then with stop-on-trap
    do_reset();
    en_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wr(A_TRAP, 64'(i));
      check("trap_pulse_hi", 80'(trap_seen_o), 80'(1'b1));
      step();
      check("trap_pulse_lo", 80'(trap_seen_o), 80'(1'b0));
    end
    check("trap_cnt3", 80'(trap_cnt_o), 80'(32'd3));
    check("trap_no_done", 80'(done_o), 80'(1'b0));
    stop_on_trap_i = 1'b1;
    wr(A_TRAP, 64'd9);
    check("trap_cnt4", 80'(trap_cnt_o), 80'(32'd4));
    wait_done(n);
    check("trap_drain_len", 80'(n), 80'(32'd501));
    check("trap_cause", 80'(done_cause_o), 80'(2'd2));

    // Streaming dumps with the consumer always ready
    do_reset();
    en_i         = 1'b1;
    dump_ready_i = 1'b1;
    step();
    for (int i = 0; i < 31; i++) begin
      exp_q.push_back({3'd0, 6'(i + 1), 64'h1000 + 64'(i)});
      wr(A_CH0, 64'h1000 + 64'(i));
      sample_head();
    end
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({3'd1, 6'(i), 64'h2000 + 64'(i)});
      wr(A_CH1, 64'h2000 + 64'(i));
      sample_head();
    end
    step();
    check("stream_empty", 80'(dump_valid_o), 80'(1'b0));
    check("stream_all_seen", 80'(exp_q.size()), 80'(32'd0));
    check("stream_no_ovf", 80'(dump_ovf_o), 80'(1'b0));

    // Overflow: ten dumps into an eight-entry FIFO with no consumer
    dump_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        exp_q.push_back({3'd0, 6'(32 + i), 64'h3000 + 64'(i)});
      end
      wr(A_CH0, 64'h3000 + 64'(i));
      if (i == 7) begin
        check("ovf_not_yet", 80'(dump_ovf_o), 80'(1'b0));
      end
    end
    check("ovf_set", 80'(dump_ovf_o), 80'(1'b1));
    dump_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_head();
      step();
    end
    check("ovf_drained", 80'(dump_valid_o), 80'(1'b0));
    exp_q.push_back({3'd0, 6'd42, 64'h4000});
    wr(A_CH0, 64'h4000);
    sample_head();
    step();

    // Cycle limit with no stop
    do_reset();
    simlen_i = 32'd100;
    en_i     = 1'b1;
    step();
    wait_done(n);
    check("simlen_cycle", 80'(cycle_cnt_o), 80'(32'd100));
    check("simlen_cause", 80'(done_cause_o), 80'(2'd3));

    // Stop at cycle 50, cycle limit 100 ends the drain early
    do_reset();
    simlen_i = 32'd100;
    en_i     = 1'b1;
    step();
    repeat (49) step();
    wr(A_STOP, 64'd0);
    wait_done(n);
    check("simlen_drain_len", 80'(n), 80'(32'd50));
    check("simlen_drain_cycle", 80'(cycle_cnt_o), 80'(32'd100));
    check("simlen_keeps_stop", 80'(done_cause_o), 80'(2'd1));

    // Async reset mid-drain with data queued, then a fresh run
    do_reset();
    en_i = 1'b1;
    step();
    wr(A_CH1, 64'h55);
    wr(A_TRAP, 64'd0);
    wr(A_STOP, 64'd0);
    repeat (3) step();
    check("pre_rst_valid", 80'(dump_valid_o), 80'(1'b1));
    rst_i = 1'b1;
    #2;
    check("arst_valid", 80'(dump_valid_o), 80'(1'b0));
    check("arst_head", 80'({dump_ch_o, dump_idx_o, dump_data_o}), 80'(73'd0));
    check("arst_trap_cnt", 80'(trap_cnt_o), 80'(32'd0));
    check("arst_cycle", 80'(cycle_cnt_o), 80'(32'd0));
    check("arst_misc", 80'({dump_ovf_o, trap_seen_o, done_o, done_cause_o}), 80'(5'd0));
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    dump_ready_i = 1'b1;
    exp_q.delete();
    step();
    exp_q.push_back({3'd0, 6'd1, 64'hBEEF});
    wr(A_CH0, 64'hBEEF);
    sample_head();
    check("rerun_cycle", 80'(cycle_cnt_o), 80'(32'd1));
    wr(A_STOP, 64'd0);
    wait_done(n);
    check("rerun_drain_len", 80'(n), 80'(32'd501));
    check("rerun_cause", 80'(done_cause_o), 80'(2'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
